// File: rtl/puff_sequencer_if.sv
// Configuration/status bundle between the MCU-side controller and puff_sequencer.
// The puff_count signal exists only when PUFF_SEQ_COUNT_EN is defined.
interface puff_sequencer_if;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        puff_event;
  logic [15:0] puff_len_us;
  logic [15:0] ign_timeout_len_jf;
  logic        puff_enable;
  logic        puff_on_timeout;
  logic [1:0]  seq_state;
  logic [1:0]  cfg_status;
`ifdef PUFF_SEQ_COUNT_EN
  logic [15:0] puff_count;
`endif

`ifdef PUFF_SEQ_COUNT_EN
  modport master (
    output cfg_wr, cfg_addr, cfg_data, puff_event,
    input  puff_len_us, ign_timeout_len_jf, puff_enable, puff_on_timeout,
           seq_state, cfg_status, puff_count
  );
  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, puff_event,
    output puff_len_us, ign_timeout_len_jf, puff_enable, puff_on_timeout,
           seq_state, cfg_status, puff_count
  );
`else
  modport master (
    output cfg_wr, cfg_addr, cfg_data, puff_event,
    input  puff_len_us, ign_timeout_len_jf, puff_enable, puff_on_timeout,
           seq_state, cfg_status
  );
  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, puff_event,
    output puff_len_us, ign_timeout_len_jf, puff_enable, puff_on_timeout,
           seq_state, cfg_status
  );
`endif
endinterface

// File: rtl/puff_sequencer.sv
// Shadow/active register sequencer feeding the puff timer.
// Define PUFF_SEQ_COUNT_EN to add the completed-puff counter (puff_count).
module puff_sequencer #(
  parameter logic [15:0] MIN_PUFF_US = 16'd300,
  parameter logic [15:0] MAX_PUFF_US = 16'd20000
) (
  input logic             sysclk,
  input logic             sysreset,
  puff_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    ARMED   = 2'd2,
    PUFFING = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] shadow_len_q, shadow_len_d;
  logic [15:0] shadow_timeout_q, shadow_timeout_d;
  logic        shadow_on_timeout_q, shadow_on_timeout_d;
  logic [15:0] act_len_q, act_len_d;
  logic [15:0] act_timeout_q, act_timeout_d;
  logic        act_on_timeout_q, act_on_timeout_d;
  logic        run_req_q, run_req_d;
  logic        pending_q, pending_d;
  logic [1:0]  status_q, status_d;
  logic        event_prev_q;
`ifdef PUFF_SEQ_COUNT_EN
  logic [15:0] count_q, count_d;
`endif

  logic        ev_rise, ev_fall, copy;
  logic [15:0] clamp_len;

  assign ev_rise = bus.puff_event & ~event_prev_q;
  assign ev_fall = ~bus.puff_event & event_prev_q;

  always_comb begin
    clamp_len = bus.cfg_data;
    if (bus.cfg_data < MIN_PUFF_US)      clamp_len = MIN_PUFF_US;
    else if (bus.cfg_data > MAX_PUFF_US) clamp_len = MAX_PUFF_US;
  end

  always_comb begin
    state_d             = state_q;
    shadow_len_d        = shadow_len_q;
    shadow_timeout_d    = shadow_timeout_q;
    shadow_on_timeout_d = shadow_on_timeout_q;
    act_len_d           = act_len_q;
    act_timeout_d       = act_timeout_q;
    act_on_timeout_d    = act_on_timeout_q;
    run_req_d           = run_req_q;
    pending_d           = pending_q;
    status_d            = status_q;
    copy                = 1'b0;
`ifdef PUFF_SEQ_COUNT_EN
    count_d             = count_q;
`endif

    // The copy is clocked on entry to LOAD so the actives are already stable
    // for the whole LOAD cycle, one cycle ahead of the puff_enable rise.
    unique case (state_q)
      IDLE: begin
        if (run_req_q) begin
          if (shadow_timeout_q != '0) begin
            state_d = LOAD;
            copy    = 1'b1;
          end else begin
            status_d[1] = 1'b1;
            run_req_d   = 1'b0;
          end
        end
      end
      LOAD: state_d = ARMED;
      ARMED: begin
        if (ev_rise)         state_d = PUFFING;
        else if (!run_req_q) state_d = IDLE;
        else if (pending_q)  copy    = 1'b1;
      end
      PUFFING: begin
        if (ev_fall) begin
`ifdef PUFF_SEQ_COUNT_EN
          count_d = count_q + 16'd1;
`endif
          if (run_req_q) begin
            state_d = ARMED;
            copy    = pending_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (copy) begin
      act_len_d        = shadow_len_q;
      act_timeout_d    = shadow_timeout_q;
      act_on_timeout_d = shadow_on_timeout_q;
      pending_d        = 1'b0;
    end

    // A write in the same cycle as a copy lands in the shadow and stays pending.
    if (bus.cfg_wr) begin
      unique case (bus.cfg_addr)
        2'd0: begin
          shadow_len_d = clamp_len;
          pending_d    = 1'b1;
          if (clamp_len != bus.cfg_data) status_d[0] = 1'b1;
        end
        2'd1: begin
          shadow_timeout_d = bus.cfg_data;
          pending_d        = 1'b1;
        end
        2'd2: begin
          run_req_d           = bus.cfg_data[0];
          shadow_on_timeout_d = bus.cfg_data[1];
          pending_d           = 1'b1;
          if (bus.cfg_data[15]) begin
            status_d = '0;
`ifdef PUFF_SEQ_COUNT_EN
            count_d  = '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_q             <= IDLE;
      shadow_len_q        <= '0;
      shadow_timeout_q    <= '0;
      shadow_on_timeout_q <= 1'b0;
      act_len_q           <= '0;
      act_timeout_q       <= '0;
      act_on_timeout_q    <= 1'b0;
      run_req_q           <= 1'b0;
      pending_q           <= 1'b0;
      status_q            <= '0;
      event_prev_q        <= 1'b0;
`ifdef PUFF_SEQ_COUNT_EN
      count_q             <= '0;
`endif
    end else begin
      state_q             <= state_d;
      shadow_len_q        <= shadow_len_d;
      shadow_timeout_q    <= shadow_timeout_d;
      shadow_on_timeout_q <= shadow_on_timeout_d;
      act_len_q           <= act_len_d;
      act_timeout_q       <= act_timeout_d;
      act_on_timeout_q    <= act_on_timeout_d;
      run_req_q           <= run_req_d;
      pending_q           <= pending_d;
      status_q            <= status_d;
      event_prev_q        <= bus.puff_event;
`ifdef PUFF_SEQ_COUNT_EN
      count_q             <= count_d;
`endif
    end
  end

  assign bus.puff_len_us        = act_len_q;
  assign bus.ign_timeout_len_jf = act_timeout_q;
  assign bus.puff_on_timeout    = act_on_timeout_q;
  assign bus.puff_enable        = (state_q == ARMED) || (state_q == PUFFING);
  assign bus.seq_state          = state_q;
  assign bus.cfg_status         = status_q;
`ifdef PUFF_SEQ_COUNT_EN
  assign bus.puff_count         = count_q;
`endif

endmodule

// File: tb/tb_puff_sequencer.sv
// Directed + randomized bench for puff_sequencer; expectations come from a
// committed-value model (shadow/active contents, sticky flags, puff count).
module tb_puff_sequencer;

  logic sysclk;
  logic sysreset;
  puff_sequencer_if bus();

  puff_sequencer #(.MIN_PUFF_US(16'd300), .MAX_PUFF_US(16'd20000)) dut (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .bus      (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model of what the MCU has written and what the timer should currently see.
  int unsigned m_len_sh, m_to_sh, m_len, m_to, m_status, m_count;
  bit          m_ont_sh, m_ont, m_run;

  function automatic int unsigned clamp(input int unsigned v);
    if (v < 300)   return 300;
    if (v > 20000) return 20000;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic mcu_write(input int unsigned addr, input int unsigned data);
    logic [15:0] d;
    d = data[15:0];
    case (addr)
      0: begin
        if (clamp(data) != data) m_status = m_status | 1;
        m_len_sh = clamp(data);
      end
      1: m_to_sh = data;
      2: begin
        m_run    = d[0];
        m_ont_sh = d[1];
        if (d[15]) begin
          m_status = 0;
          m_count  = 0;
        end
      end
      default: ;
    endcase
    bus.cfg_wr   = 1'b1;
    bus.cfg_addr = addr[1:0];
    bus.cfg_data = d;
    tick();
    bus.cfg_wr   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
  endtask

  task automatic m_commit();
    m_len = m_len_sh;
    m_to  = m_to_sh;
    m_ont = m_ont_sh;
  endtask

  task automatic m_reset();
    m_len_sh = 0; m_to_sh = 0; m_ont_sh = 0;
    m_len = 0; m_to = 0; m_ont = 0;
    m_run = 0; m_status = 0; m_count = 0;
  endtask

  task automatic check_view(input string tag, input int unsigned st, input bit en);
    chk({tag, ".state"}, bus.seq_state, st);
    chk({tag, ".enable"}, bus.puff_enable, en);
    chk({tag, ".len"}, bus.puff_len_us, m_len);
    chk({tag, ".timeout"}, bus.ign_timeout_len_jf, m_to);
    chk({tag, ".on_to"}, bus.puff_on_timeout, m_ont);
    chk({tag, ".status"}, bus.cfg_status, m_status);
`ifdef PUFF_SEQ_COUNT_EN
    chk({tag, ".count"}, bus.puff_count, m_count);
`endif
  endtask

  initial begin
    int unsigned a, d, hold;
    sysreset       = 1'b1;
    bus.cfg_wr     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.puff_event = 1'b0;
    m_reset();
    tick(); tick(); tick();
    check_view("reset", 0, 0);
    sysreset = 1'b0;
    tick();

    // Basic arm: actives visible during LOAD, enable one cycle later.
    mcu_write(0, 5000);
    mcu_write(1, 2000);
    mcu_write(2, 1);
    check_view("arm_idle", 0, 0);
    tick();
    m_commit();
    check_view("arm_load", 1, 0);
    tick();
    check_view("arm_armed", 2, 1);

    // Random writes while ARMED are copied in place one cycle later.
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 3);
      case (a)
        0: d = $urandom_range(0, 65535);
        1: d = $urandom_range(1, 65535);
        2: d = ($urandom & 32'h8002) | 1;
        default: d = $urandom_range(0, 65535);
      endcase
      mcu_write(a, d);
      tick();
      m_commit();
      check_view("armed_wr", 2, 1);
    end

    // Random puffs, with writes deferred until the puff_event fall.
    for (int i = 0; i < 8; i++) begin
      bus.puff_event = 1'b1;
      tick();
      check_view("puff_start", 3, 1);
      if ($urandom_range(0, 1) == 1)
        mcu_write(0, (i == 0) ? 8000 : $urandom_range(0, 65535));
      else
        mcu_write(1, $urandom_range(1, 65535));
      check_view("puff_defer", 3, 1);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < int'(hold); h++) begin
        tick();
        check_view("puff_hold", 3, 1);
      end
      bus.puff_event = 1'b0;
      tick();
      m_commit();
      m_count++;
      check_view("puff_end", 2, 1);
      tick();
    end

    // Run request dropped mid-puff: the puff completes, then IDLE without copy.
    bus.puff_event = 1'b1;
    tick();
    mcu_write(2, 0);
    check_view("stop_mid", 3, 1);
    tick();
    check_view("stop_hold", 3, 1);
    bus.puff_event = 1'b0;
    tick();
    m_count++;
    check_view("stop_idle", 0, 0);

    // Re-arm, then reset in the middle of a puff.
    mcu_write(2, 1);
    tick();
    m_commit();
    check_view("rearm_load", 1, 0);
    tick();
    check_view("rearm_armed", 2, 1);
    bus.puff_event = 1'b1;
    tick();
    check_view("rst_puff", 3, 1);
    sysreset = 1'b1;
    tick();
    m_reset();
    check_view("rst_mid", 0, 0);
    sysreset       = 1'b0;
    bus.puff_event = 1'b0;
    tick();

    // Zero timeout refuses the start.
    mcu_write(1, 0);
    mcu_write(2, 1);
    tick();
    m_status = m_status | 2;
    m_run    = 0;
    check_view("refuse", 0, 0);
    tick();
    check_view("refuse_stay", 0, 0);
    mcu_write(2, 16'h8000);
    check_view("status_clr", 0, 0);

    // Clamping at both bounds.
    mcu_write(0, 50);
    mcu_write(1, 1234);
    mcu_write(2, 1);
    tick();
    m_commit();
    check_view("clamp_lo", 1, 0);
    tick();
    mcu_write(0, 30000);
    tick();
    m_commit();
    check_view("clamp_hi", 2, 1);

    // Address 3 is ignored.
    mcu_write(3, 16'h1234);
    tick();
    check_view("addr3", 2, 1);

    // Control clear of status and (when present) puff counter.
    bus.puff_event = 1'b1;
    tick();
    bus.puff_event = 1'b0;
    tick();
    m_count++;
    check_view("last_puff", 2, 1);
    mcu_write(2, 16'h8001);
    tick();
    m_commit();
    check_view("ctrl_clr", 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puff_sequencer.md
PUFF_SEQUENCER -- requirements
Module: puff_sequencer

Interface
REQ-001 Parameter MIN_PUFF_US, default 16'd300: lower clamp for puff length, in microseconds.
REQ-002 Parameter MAX_PUFF_US, default 16'd20000: upper clamp for puff length, in microseconds.
REQ-003 sysclk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 sysreset  in  1  synchronous, active-high reset.
REQ-005 cfg_wr  in  1  MCU write strobe, one sysclk wide.
REQ-006 cfg_addr  in  2  write target: 0 = puff length, 1 = ignition timeout, 2 = control, 3 = ignored.
REQ-007 cfg_data  in  16  write data.
REQ-008 puff_event  in  1  injector-open indication from the puff timer.
REQ-009 puff_len_us  out  16  active puff length, driven to the puff timer.
REQ-010 ign_timeout_len_jf  out  16  active ignition timeout, in 50 kHz ticks, driven to the puff timer.
REQ-011 puff_enable  out  1  enable to the puff timer.
REQ-012 puff_on_timeout  out  1  fire-on-timeout enable to the puff timer.
REQ-013 seq_state  out  2  current state encoding: IDLE=0, LOAD=1, ARMED=2, PUFFING=3.
REQ-014 cfg_status  out  2  sticky flags: bit0 = clamp occurred, bit1 = start refused.

Function
REQ-015 Shadow registers SHALL be written in the cycle cfg_wr is high.
- Address 0: shadow_len, clamped into [MIN_PUFF_US, MAX_PUFF_US]; cfg_status[0] SHALL set if clamping altered the value.
- Address 1: shadow_timeout, unclamped.
- Address 2: cfg_data[0] = run request (run_req); cfg_data[1] = shadow_on_timeout; cfg_data[15] = 1 clears cfg_status.
REQ-016 Active outputs puff_len_us, ign_timeout_len_jf and puff_on_timeout SHALL change only on a shadow-to-active copy, never while in ARMED or PUFFING except as stated in REQ-019.
REQ-017 IDLE: puff_enable = 0. When run_req = 1 and shadow_timeout != 0, go to LOAD. When run_req = 1 and shadow_timeout = 0, set cfg_status[1], clear run_req, and stay in IDLE.
REQ-018 LOAD: lasts exactly one cycle. Copy all shadows to active, then go to ARMED. puff_enable SHALL rise in the cycle after the copy, so the active registers are stable at least one cycle before the puff_enable posedge.
REQ-019 ARMED: puff_enable = 1.
- puff_event rising edge: go to PUFFING.
- run_req = 0: go to IDLE.
- A shadow write pending since the last copy: perform the copy in place, staying in ARMED with puff_enable held at 1.
REQ-020 PUFFING: puff_enable = 1, and shadow writes are deferred. On puff_event falling edge:
- If run_req = 1: apply any pending copy and go to ARMED.
- If run_req = 0: go to IDLE.
REQ-021 A run_req clear during PUFFING SHALL NOT truncate the in-progress puff.
REQ-022 Edge detection on puff_event SHALL use a one-cycle registered copy; puff_event is already synchronous to sysclk.
REQ-023 Simultaneous cfg_wr and state transition: the write SHALL land in the shadow, and any copy SHALL take effect on the next eligible cycle.
REQ-024 Clamp comparisons SHALL be unsigned 16-bit.
REQ-025 Writes with cfg_addr = 3 SHALL have no effect.

Reset
REQ-026 While sysreset is high, the block SHALL hold: state IDLE, all shadow and active registers 0, run_req 0, puff_enable 0, puff_on_timeout 0, cfg_status 0, and the previous-cycle puff_event register 0.
REQ-027 Reset asserted mid-puff SHALL drop puff_enable on the next sysclk edge, with no drain.

Configuration
REQ-028 With PUFF_SEQ_COUNT_EN defined, the block SHALL add output puff_count (16 bits).
- puff_count increments on each puff_event falling edge seen in PUFFING.
- It wraps from 16'hFFFF to 0.
- It is cleared by reset or by a control write with cfg_data[15] = 1.
REQ-029 Without PUFF_SEQ_COUNT_EN, neither the puff_count port nor its counter logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-030 Write len=5000, timeout=2000, then ctrl=1 -> seq_state goes 0,1,2. ign_timeout_len_jf=2000 and puff_len_us=5000 one cycle before puff_enable rises.
REQ-031 Write len=50 -> puff_len_us=300 at the next copy, and cfg_status[0]=1. Write len=30000 -> puff_len_us=20000.
REQ-032 Write timeout=0 then ctrl=1 -> stays IDLE, cfg_status[1]=1, puff_enable stays 0.
REQ-033 In PUFFING, write len=8000 -> puff_len_us holds its old value until the puff_event fall, then becomes 8000 in ARMED.
REQ-034 ctrl=0 during PUFFING -> puff_enable stays 1 until the puff_event fall, then IDLE. Reset during PUFFING -> puff_enable=0 the next cycle.
REQ-035 With PUFF_SEQ_COUNT_EN and puff_count preset to 16'hFFFF via 65535 puffs -> one more puff gives puff_count=0. A ctrl write with bit15=1 clears it.
